// File: rtl/xor_cipher_ctrl.sv
// xor_cipher_ctrl
// ---------------------------------------------------------------------------
// Sequencing controller for the XOR cipher datapath. Latches a key-bank
// selection at the start of a message, drives the bank select and key-ROM
// address into the key connector, walks the key bytes cyclically and XORs
// each incoming byte with the current key byte.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   start, key_sel[1:0] : begin a message with the requested key bank
//   key_o[1:0]          : registered bank select to the key connector
//   r_a[3:0]            : registered key-ROM address to the key connector
//   r_d[7:0]            : key byte from the key connector (1-cycle sync ROM)
//   in_data/last/valid  : input byte stream, in_ready accepts it
//   out_data/last/valid : registered result stream, out_ready drains it
//   busy                : high whenever the controller is not idle
//   done                : one-cycle pulse after the last result is consumed
//   key_err             : one-cycle pulse when start requests bank 3
// ---------------------------------------------------------------------------
module xor_cipher_ctrl #(
    parameter int KEY_LEN = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] key_sel,
    output logic [1:0] key_o,
    output logic [3:0] r_a,
    input  logic [7:0] r_d,
    input  logic [7:0] in_data,
    input  logic       in_last,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done,
    output logic       key_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(KEY_LEN - 1);

    state_t     state;
    state_t     state_next;
    logic [3:0] key_idx;
    logic [3:0] idx_next;
    logic       start_ok;
    logic       start_bad;
    logic       accept;
    logic       drain;
    logic       finish;

    // The key index register is itself the ROM address, so r_a follows the
    // index without an extra cycle of delay.
    assign r_a = key_idx;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next = FETCH;
                end
            end
            // One cycle for the synchronous key ROM to produce r_d.
            FETCH: begin
                state_next = READY;
            end
            READY: begin
                if (accept) begin
                    state_next = in_last ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if (drain) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output / strobe logic
    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == READY) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        drain     = out_valid && out_ready;
        start_ok  = (state == IDLE) && start && (key_sel != 2'b11);
        start_bad = (state == IDLE) && start && (key_sel == 2'b11);
        finish    = (state == FLUSH) && drain;
        idx_next  = (key_idx == LAST_IDX) ? 4'd0 : key_idx + 4'd1;
    end

    // Bank select and key index: the bank is captured only on a legal start,
    // so an illegal request or a start during a message leaves it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_o   <= 2'd0;
            key_idx <= 4'd0;
        end else begin
            if (start_ok) begin
                key_o   <= key_sel;
                key_idx <= 4'd0;
            end else if (accept && !in_last) begin
                key_idx <= idx_next;
            end
        end
    end

    // Output register: a new accept takes priority over a drain in the same
    // cycle, which keeps out_valid high with the fresh result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= 8'd0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                out_data  <= in_data ^ r_d;
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            key_err <= 1'b0;
        end else begin
            done    <= finish;
            key_err <= start_bad;
        end
    end

endmodule

// File: doc/xor_cipher_ctrl.md
# xor_cipher_ctrl

Sequencing controller for the XOR cipher datapath. It latches a key-bank selection, drives the key-bank select and key-ROM address into the key connector, walks the key bytes cyclically, and XORs each incoming byte stream element with the current key byte. Input and output use valid/ready handshakes. It sits between the byte source (UART/switch front end) and the byte sink, and is the only master of the connector's select and address inputs.

## Interface

**Parameters**
- `KEY_LEN`, default 16: number of key bytes used before the address wraps. Legal range is 1..16.

**Ports**
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begin a message. Sampled only in IDLE.
- `key_sel`, in, 2: key bank requested. Sampled with `start`.
- `key_o`, out, 2: bank select to the connector's `key` input. Registered.
- `r_a`, out, 4: key-ROM address to the connector's `r_a_in`. Registered.
- `r_d`, in, 8: key byte from the connector's `r_d_out`.
- `in_data`, in, 8: plaintext or ciphertext byte.
- `in_last`, in, 1: marks the final byte of the message.
- `in_valid`, in, 1: source has a byte.
- `in_ready`, out, 1: controller accepts the byte this cycle.
- `out_data`, out, 8: result byte. Registered.
- `out_last`, out, 1: result is the final byte.
- `out_valid`, out, 1: result available.
- `out_ready`, in, 1: sink accepts the result.
- `busy`, out, 1: high whenever state is not IDLE.
- `done`, out, 1: one-cycle pulse when the last result is consumed.
- `key_err`, out, 1: one-cycle pulse when `start` arrives with `key_sel == 2'b11`.

## Operation

- **Reset.** All registered outputs go to 0: `key_o`, `r_a`, `out_data`, `out_last`, `out_valid`, `done`, `key_err`. State goes to IDLE. Key index goes to 0. Reset mid-message aborts immediately; any pending output is dropped.
- **IDLE**
  - `start` with `key_sel` in 0..2: latch `key_sel` into `key_o`, set index and `r_a` to 0, go to FETCH.
  - `start` with `key_sel == 3`: pulse `key_err`, stay in IDLE, leave `key_o` unchanged.
- **FETCH.** One cycle. The address is stable on `r_a` while the key ROM (synchronous, 1-cycle read) produces the byte. Always go to READY.
- **READY**
  - `r_d` is valid. `in_ready = !out_valid || out_ready`.
  - On accept (`in_valid && in_ready`): `out_data <= in_data ^ r_d`, `out_last <= in_last`, `out_valid <= 1`.
  - If `in_last`, go to FLUSH.
  - Otherwise, index advances: it becomes 0 if index == `KEY_LEN-1`, else index+1. `r_a` follows the index. Go to FETCH.
- **FLUSH.** `in_ready = 0`. When `out_valid && out_ready`: clear `out_valid`, pulse `done`, go to IDLE.
- **Output register.** `out_valid` clears on `out_ready` when no new accept occurs in the same cycle. A simultaneous accept and drain keeps `out_valid` high with the new data.
- `in_ready` is 0 in IDLE, FETCH and FLUSH.
- `start` outside IDLE is ignored.
- `key_o` is held constant for the entire message.
- `busy` is high in FETCH, READY and FLUSH.

## Timing

- Result latency: a byte accepted at edge N appears with `out_valid` high in cycle N+1.
- Maximum throughput is 1 byte per 2 cycles (FETCH/READY alternation).
- From `start` sampled at edge 0: FETCH during cycle 1, READY (first possible accept) during cycle 2.
- `done` is asserted in the cycle after the edge at which the last result is consumed. `busy` is 0 in that same cycle.
- Backpressure: while `out_valid && !out_ready`, `out_data` and `out_last` stay stable, and `in_ready` stays 0 in READY.
- When `KEY_LEN == 1`, `r_a` remains 0 throughout the message.

## Test plan

- **Basic encrypt.** Bank 0 ROM[0]=0x5A, ROM[1]=0x3C. `key_sel=0`, `start`, then bytes 0x41, 0x42 (last). Outputs must be 0x1B then 0x7E (`out_last=1`), followed by a single `done` pulse; `key_o` = 0 throughout.
- **Key wrap.** `KEY_LEN=4`, `key_sel=2`, 6-byte message. `r_a` sequence must be 0,1,2,3,0,1, and each output must equal the input XOR bank-2 ROM[r_a].
- **Illegal bank.** `start` with `key_sel=3`: `key_err` high for exactly 1 cycle, `busy` stays 0, `in_ready` stays 0, `key_o` unchanged.
- **Backpressure.** Hold `out_ready=0` for 5 cycles after the first result. `out_data` must stay stable, `in_ready` must stay 0, and no byte may be lost. The next output follows once `out_ready` rises.
- **Reset mid-message.** Assert `rst_n=0` after the third accepted byte. All outputs must read 0 in the same cycle, and a new `start` must restart at `r_a=0`.
- **Start while busy.** Pulse `start` with `key_sel=1` during a bank-0 message. `key_o` must stay 0 and the message must complete normally.
